// File: rtl/vga_logo_pkg.sv
// Shared constants and state encoding for the logo painters and their scroll controller.
package vga_logo_pkg;

   localparam int unsigned DEF_W           = 11;
   localparam int unsigned DEF_MAX_DELT    = 200;
   localparam int unsigned DEF_STEP        = 2;
   localparam int unsigned DEF_HOLD_FRAMES = 30;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RIGHT  = 3'd1,
      HOLD_R = 3'd2,
      LEFT   = 3'd3,
      HOLD_L = 3'd4
   } scroll_state_e;

   // Last frame-counter value before a step; a speed of 0 behaves like 1.
   function automatic logic [3:0] step_limit_m1(input logic [3:0] speed);
      return (speed == 4'd0) ? 4'd0 : speed - 4'd1;
   endfunction

endpackage

// File: rtl/vsync_edge_det.sv
// Detects the falling edge of vsync; fall_c is the raw edge, frame_tick its registered pulse.
module vsync_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic vsync,
   output logic fall_c,
   output logic frame_tick
);

   logic hist_q;

   assign fall_c = hist_q & ~vsync;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist_q     <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         hist_q     <= vsync;
         frame_tick <= fall_c;
      end
   end

endmodule

// File: rtl/logo_scroll_ctrl.sv
// Frame-synchronous bounce sequencer producing the shared logo offset, direction and enable.
module logo_scroll_ctrl
   import vga_logo_pkg::*;
#(
   parameter int unsigned W           = DEF_W,
   parameter int unsigned MAX_DELT    = DEF_MAX_DELT,
   parameter int unsigned STEP        = DEF_STEP,
   parameter int unsigned HOLD_FRAMES = DEF_HOLD_FRAMES
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         vsync,
   input  logic         pause,
   input  logic [3:0]   speed,
   output logic [W-1:0] delt,
   output logic         enable,
   output logic         dir,
   output logic         frame_tick
);

   localparam int unsigned WP = W + 1;
   localparam int unsigned HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

   scroll_state_e state_q, state_d;
   logic [W-1:0]  delt_q, delt_d;
   logic          en_q, en_d;
   logic          dir_q, dir_d;
   logic [3:0]    fcnt_q, fcnt_d;
   logic [HW-1:0] hcnt_q, hcnt_d;
   logic [W:0]    sum_c;
   logic          step_c;
   logic          fall_c;

   vsync_edge_det u_edge (
      .clk        (clk),
      .rst        (rst),
      .vsync      (vsync),
      .fall_c     (fall_c),
      .frame_tick (frame_tick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         delt_q  <= '0;
         en_q    <= 1'b0;
         dir_q   <= 1'b0;
         fcnt_q  <= '0;
         hcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         delt_q  <= delt_d;
         en_q    <= en_d;
         dir_q   <= dir_d;
         fcnt_q  <= fcnt_d;
         hcnt_q  <= hcnt_d;
      end
   end

   // Everything advances only on an unpaused frame edge, so delt is stable within a frame.
   always_comb begin
      state_d = state_q;
      delt_d  = delt_q;
      en_d    = en_q;
      dir_d   = dir_q;
      fcnt_d  = fcnt_q;
      hcnt_d  = hcnt_q;
      sum_c   = {1'b0, delt_q} + WP'(STEP);
      step_c  = (fcnt_q >= step_limit_m1(speed));

      if (fall_c && !pause) begin
         case (state_q)
            IDLE: begin
               en_d    = 1'b1;
               state_d = RIGHT;
            end
            RIGHT: begin
               if (step_c) begin
                  fcnt_d = '0;
                  if (sum_c >= WP'(MAX_DELT)) begin
                     delt_d  = W'(MAX_DELT);
                     hcnt_d  = '0;
                     state_d = HOLD_R;
                  end else begin
                     delt_d = sum_c[W-1:0];
                  end
               end else begin
                  fcnt_d = fcnt_q + 4'd1;
               end
            end
            HOLD_R: begin
               if (hcnt_q == HW'(HOLD_FRAMES - 1)) begin
                  dir_d   = 1'b1;
                  fcnt_d  = '0;
                  state_d = LEFT;
               end else begin
                  hcnt_d = hcnt_q + HW'(1);
               end
            end
            LEFT: begin
               if (step_c) begin
                  fcnt_d = '0;
                  if (delt_q <= W'(STEP)) begin
                     delt_d  = '0;
                     hcnt_d  = '0;
                     state_d = HOLD_L;
                  end else begin
                     delt_d = delt_q - W'(STEP);
                  end
               end else begin
                  fcnt_d = fcnt_q + 4'd1;
               end
            end
            HOLD_L: begin
               if (hcnt_q == HW'(HOLD_FRAMES - 1)) begin
                  dir_d   = 1'b0;
                  fcnt_d  = '0;
                  state_d = RIGHT;
               end else begin
                  hcnt_d = hcnt_q + HW'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign delt   = delt_q;
   assign enable = en_q;
   assign dir    = dir_q;

endmodule
